// File: rtl/fpu_mantissa_divider_seq.sv
// fpu_mantissa_divider_seq: multi-cycle restoring divider producing floor((a<<27)/b) with sticky, div-by-zero and a pass-through tag.
module fpu_mantissa_divider_seq #(
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [23:0]          in_dividend,
  input  logic [23:0]          in_divisor,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [50:0]          out_quotient,
  output logic                 out_sticky,
  output logic                 out_div_by_zero,
  output logic [TAG_WIDTH-1:0] out_tag
);
  localparam int STEPS = 51 / BITS_PER_CYCLE;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [24:0] r, r_n;
  logic [50:0] d, d_n, q, q_n;
  logic [23:0] dv;
  logic [5:0] cnt;
  logic dz;
  logic [TAG_WIDTH-1:0] tag;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (in_valid ? BUSY : IDLE)
            : state == BUSY ? (cnt == 6'd1 ? DONE : BUSY)
            : (out_ready ? IDLE : DONE);
  end
  // R < b holds before every shift, so R[24] is always zero and can be dropped
  always_comb begin
    r_n = r;
    d_n = d;
    q_n = q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      r_n = {r_n[23:0], d_n[50]};
      d_n = {d_n[49:0], 1'b0};
      q_n = {q_n[49:0], r_n >= {1'b0, dv}};
      r_n = q_n[0] ? r_n - {1'b0, dv} : r_n;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r <= '0;
      d <= '0;
      q <= '0;
      dv <= '0;
      cnt <= '0;
      dz <= 1'b0;
      tag <= '0;
      out_quotient <= '0;
      out_sticky <= 1'b0;
      out_div_by_zero <= 1'b0;
      out_tag <= '0;
    end else if (state == IDLE && in_valid) begin
      r <= '0;
      d <= {in_dividend, 27'b0};
      q <= '0;
      dv <= in_divisor;
      cnt <= 6'(STEPS);
      dz <= in_divisor == 24'd0;
      tag <= in_tag;
    end else if (state == BUSY) begin
      r <= r_n;
      d <= d_n;
      q <= q_n;
      cnt <= cnt - 6'd1;
      if (cnt == 6'd1) begin
        out_quotient <= dz ? '1 : q_n;
        out_sticky <= !dz && r_n != 25'd0;
        out_div_by_zero <= dz;
        out_tag <= tag;
      end
    end
endmodule

// File: tb/tb_fpu_mantissa_divider_seq.sv
// tb_fpu_mantissa_divider_seq: directed and random checks of both divider widths against an arithmetic reference.
module tb_fpu_mantissa_divider_seq;
  logic clk = 0, rst = 1;
  logic iv[2], ir[2], ov[2], ordy[2], os[2], odz[2];
  logic [23:0] ia[2], ib[2], eb[2];
  logic [10:0] it[2], ot[2], et[2];
  logic [50:0] oq[2];
  logic [51:0] ex[2];
  int acc[2], cyc = 0, checks = 0, failures = 0;
  bit seen[2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_mantissa_divider_seq #(.BITS_PER_CYCLE(1), .TAG_WIDTH(11)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_dividend(ia[0]),
    .in_divisor(ib[0]), .in_tag(it[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_quotient(oq[0]), .out_sticky(os[0]), .out_div_by_zero(odz[0]), .out_tag(ot[0]));
  fpu_mantissa_divider_seq #(.BITS_PER_CYCLE(3), .TAG_WIDTH(11)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_dividend(ia[1]),
    .in_divisor(ib[1]), .in_tag(it[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_quotient(oq[1]), .out_sticky(os[1]), .out_div_by_zero(odz[1]), .out_tag(ot[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [51:0] model(input logic [23:0] a, input logic [23:0] b);
    logic [63:0] num;
    num = 64'(a) << 27;
    if (b == 0) return {1'b0, {51{1'b1}}};
    return {(num % 64'(b)) != 0, 51'(num / 64'(b))};
  endfunction

  always @(negedge clk)
    for (int u = 0; u < 2; u++)
      if (ov[u]) begin
        chk("quotient", oq[u], ex[u][50:0]);
        chk("sticky", os[u], ex[u][51]);
        chk("div_by_zero", odz[u], eb[u] == 0);
        chk("tag", ot[u], et[u]);
        if (!seen[u]) begin
          chk("latency", cyc - acc[u], u == 0 ? 51 : 17);
          seen[u] = 1;
        end
      end

  task automatic start(input int u, input logic [23:0] a, input logic [23:0] b, input logic [10:0] tg);
    int n = 0;
    @(negedge clk);
    while (!ir[u] && n < 200) begin @(negedge clk); n++; end
    if (!ir[u]) chk("in_ready_timeout", 0, 1);
    iv[u] = 1; ia[u] = a; ib[u] = b; it[u] = tg;
    ex[u] = model(a, b); eb[u] = b; et[u] = tg;
    @(posedge clk);
    @(negedge clk);
    acc[u] = cyc; seen[u] = 0;
    iv[u] = 0; ia[u] = 24'($urandom); ib[u] = 24'($urandom); it[u] = 11'($urandom);
  endtask

  task automatic op(input int u, input logic [23:0] a, input logic [23:0] b, input logic [10:0] tg,
                    input int hold, input logic use_lit, input logic [50:0] lit);
    int n = 0;
    start(u, a, b, tg);
    while (!ov[u] && n < 200) begin
      if (u == 0) chk("busy_in_ready", ir[u], 0);
      @(negedge clk); n++;
    end
    if (!ov[u]) chk("out_valid_timeout", 0, 1);
    if (use_lit) chk("literal_quotient", oq[u], lit);
    repeat (hold) begin @(negedge clk); chk("hold_valid", ov[u], 1); chk("hold_in_ready", ir[u], 0); end
    ordy[u] = 1;
    @(posedge clk);
    @(negedge clk);
    ordy[u] = 0;
    chk("post_valid", ov[u], 0);
    chk("post_in_ready", ir[u], 1);
    chk("retain_quotient", oq[u], ex[u][50:0]);
  endtask

  initial begin
    logic [23:0] a, b;
    for (int u = 0; u < 2; u++) begin
      iv[u] = 0; ordy[u] = 0; ia[u] = 0; ib[u] = 0; it[u] = 0; seen[u] = 1; ex[u] = 0; eb[u] = 1; et[u] = 0;
    end
    #12;
    chk("rst_in_ready", ir[0], 1);
    chk("rst_out_valid", ov[0], 0);
    chk("rst_quotient", oq[0], 0);
    chk("rst_tag", ot[0], 0);
    chk("model_pin_one", model(24'h800000, 24'h800000), {1'b0, 51'h8000000});
    chk("model_pin_third", model(24'h800000, 24'hC00000), {1'b1, 51'h5555555});
    chk("model_pin_dz", model(24'hABCDEF, 24'h0), {1'b0, 51'h7FFFFFFFFFFFF});
    @(negedge clk) rst = 0;
    op(0, 24'h800000, 24'h800000, 11'h001, 0, 1, 51'h8000000);
    op(0, 24'hC00000, 24'h800000, 11'h002, 0, 1, 51'hC000000);
    op(0, 24'h800000, 24'hC00000, 11'h003, 0, 1, 51'h5555555);
    op(0, 24'hABCDEF, 24'h000000, 11'h5A5, 0, 1, 51'h7FFFFFFFFFFFF);
    op(0, 24'h000000, 24'h123456, 11'h004, 0, 1, 51'h0);
    op(0, 24'h345678, 24'h000007, 11'h111, 10, 0, 0);
    op(0, 24'h000001, 24'hFFFFFF, 11'h222, 0, 0, 0);
    start(0, 24'h654321, 24'h000123, 11'h333);
    repeat (19) @(negedge clk);
    #1 rst = 1;
    #1 chk("async_rst_in_ready", ir[0], 1);
    chk("async_rst_out_valid", ov[0], 0);
    chk("async_rst_quotient", oq[0], 0);
    @(negedge clk) rst = 0;
    op(0, 24'hFFFFFF, 24'hFFFFFF, 11'h444, 0, 1, 51'h8000000);
    op(1, 24'h800000, 24'hC00000, 11'h055, 0, 1, 51'h5555555);
    for (int i = 0; i < 1500; i++) begin
      a = i == 0 || i % 7 == 0 ? 24'hFFFFFF : i == 4 ? 24'h0 : 24'($urandom);
      b = i == 1 || i % 11 == 0 ? 24'h1 : i == 2 ? 24'h0 : i == 3 ? 24'hFFFFFF
        : i % 4 == 0 ? 24'($urandom_range(1, 255)) : 24'($urandom_range(1, 24'hFFFFFF));
      op(1, a, b, 11'($urandom), 0, 0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
